ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard: LED set (0xED + mask), reset (0xFF), enable scanning (0xF4), and similar.
- It is the opposite direction of the existing keyboard receive path, which delivers scan codes to the game logic.
- It drives the shared PS/2 clock and data lines open-collector style through pull-low enables. While it runs, the receive path must ignore the bus (gated by busy).

Parameters:
- INHIBIT_CYCLES, 5000: system clocks the host holds PS/2 clock low before the start bit (100 us at 50 MHz).
- START_SETUP_CYCLES, 50: system clocks data is held low, with clock still low, before clock is released.
- TIMEOUT_CYCLES, 1000000: maximum system clocks from clock release to completion (20 ms at 50 MHz).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle request; sampled only in IDLE.
- tx_data  in  8  byte to send; latched when tx_start is accepted.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high from the cycle after accept until the cycle tx_done or err_timeout pulses.
- tx_done  out  1  one-cycle pulse on normal completion.
- ack_ok  out  1  valid with tx_done: 1 = device pulled data low in the ack slot.
- err_timeout  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, counters 0. Reset mid-transfer releases both lines immediately.
- Input synchronisation:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser.
  - A falling edge is previous synchronised = 1 and current = 0.
- Frame content: 8 data bits LSB first, then odd parity (parity = ~^tx_data), then stop = 1 (line released).
- Line driving: a bit value of 0 drives oe = 1; a bit value of 1 drives oe = 0.
- IDLE:
  - tx_start = 1 latches tx_data, clears counters and goes to INHIBIT.
  - tx_start while not IDLE is ignored.
- INHIBIT: ps2_clk_oe = 1 for INHIBIT_CYCLES cycles, then go to START.
- START:
  - ps2_clk_oe = 1 and ps2_data_oe = 1 for START_SETUP_CYCLES cycles.
  - Then ps2_clk_oe = 0 (release), the timeout counter starts, go to SEND.
- SEND, bit index 0..9:
  - On each synchronised falling edge of PS/2 clock, drive the next frame bit and increment the index.
  - Data is held until the next falling edge.
  - After the falling edge that presents stop (index becomes 10), ps2_data_oe = 0; go to WAIT_ACK.
- WAIT_ACK:
  - On the next falling edge, sample synchronised data: ack_ok_reg = ~data.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - When synchronised clock = 1 and data = 1, pulse tx_done with ack_ok = ack_ok_reg, then go to IDLE.
  - ack_ok holds its value until the next accept.
- Timeout:
  - Counts in SEND, WAIT_ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses err_timeout, returns to IDLE, and leaves ack_ok = 0.
  - tx_done does not pulse on a timeout.
- Simultaneous events: a falling edge and a timeout in the same cycle resolve as timeout.
- Latency:
  - tx_start to ps2_clk_oe rising: 1 cycle.
  - Synchronised edge to data change: at most 3 system clocks after the raw line edge.
- Counter widths: sized for the parameter values. Counters saturate and never wrap.
- busy is derived directly from state != IDLE. It falls in the same cycle tx_done or err_timeout pulses.

Test Plan:
- Common setup: INHIBIT_CYCLES=10, START_SETUP_CYCLES=4, TIMEOUT_CYCLES=2000; device model toggles PS/2 clock with a 40-cycle period.
- Accept and inhibit: tx_start with 0xED -> busy=1; ps2_clk_oe=1 for exactly 10 cycles; ps2_data_oe=1 and remains 1 for 4 cycles before clock release.
- Frame bits: 0xED -> device samples 1,0,1,1,0,1,1,1, parity 1, stop 1 on rising edges; model acks -> tx_done pulse with ack_ok=1; busy=0.
- Parity: 0xF4 -> parity bit 0; 0x00 -> parity bit 1; data bits match LSB-first order.
- No ack: device leaves data high in the 11th clock -> tx_done with ack_ok=0.
- Timeout: device stops clocking after 3 edges -> err_timeout pulse at 2000 cycles after clock release; both oe=0; no tx_done.
- Reset and ignore: assert reset during SEND -> both oe=0 immediately. After release, a tx_start while busy is ignored and the original byte completes unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives the open-collector PS/2 clock/data lines through pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int START_SETUP_CYCLES = 50,
    parameter int TIMEOUT_CYCLES     = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_tx_done,
    output logic       o_ack_ok,
    output logic       o_err_timeout
);
    localparam int PH_MAX = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES : START_SETUP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_WAIT_ACK, S_WAIT_IDLE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [PH_W-1:0]    r_ph_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [3:0]         r_bit_idx;
    logic [9:0]         r_frame;
    logic               r_ack_reg;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_tx_done;
    logic               r_ack_ok;
    logic               r_err_timeout;

    logic               w_clk;
    logic               w_data;
    logic               w_clk_fall;
    logic               w_counting;
    logic               w_tmo_hit;
    logic [TMO_W-1:0]   w_tmo_next;

    // Bit 2 of the clock chain is the previous synchronised sample for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk_in};
            r_data_sync <= {r_data_sync[0], i_ps2_data_in};
        end
    end

    assign w_clk      = r_clk_sync[1];
    assign w_data     = r_data_sync[1];
    assign w_clk_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_counting = (r_state == S_SEND) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_IDLE);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_tmo_next = (r_tmo_cnt == '1) ? r_tmo_cnt : r_tmo_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_ph_cnt      <= '0;
            r_tmo_cnt     <= '0;
            r_bit_idx     <= '0;
            r_frame       <= '0;
            r_ack_reg     <= 1'b0;
            r_clk_oe      <= 1'b0;
            r_data_oe     <= 1'b0;
            r_tx_done     <= 1'b0;
            r_ack_ok      <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_tx_done     <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_counting) begin
                r_tmo_cnt <= w_tmo_next;
            end
            // Timeout wins over any falling edge seen in the same cycle.
            if (w_counting && w_tmo_hit) begin
                r_state       <= S_IDLE;
                r_clk_oe      <= 1'b0;
                r_data_oe     <= 1'b0;
                r_ack_ok      <= 1'b0;
                r_err_timeout <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_tx_start) begin
                            r_frame   <= {1'b1, ~^i_tx_data, i_tx_data};
                            r_ph_cnt  <= '0;
                            r_tmo_cnt <= '0;
                            r_bit_idx <= '0;
                            r_ack_reg <= 1'b0;
                            r_ack_ok  <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
                            r_ph_cnt  <= '0;
                            r_data_oe <= 1'b1;
                            r_state   <= S_START;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_START: begin
                        if (r_ph_cnt == PH_W'(START_SETUP_CYCLES - 1)) begin
                            r_clk_oe  <= 1'b0;
                            r_tmo_cnt <= '0;
                            r_state   <= S_SEND;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_frame[0];
                            r_frame   <= {1'b0, r_frame[9:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            if (r_bit_idx == 4'd9) begin
                                r_state <= S_WAIT_ACK;
                            end
                        end
                    end
                    S_WAIT_ACK: begin
                        if (w_clk_fall) begin
                            r_ack_reg <= ~w_data;
                            r_state   <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_clk && w_data) begin
                            r_tx_done <= 1'b1;
                            r_ack_ok  <= r_ack_reg;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign o_busy        = (r_state != S_IDLE);
    assign o_tx_done     = r_tx_done;
    assign o_ack_ok      = r_ack_ok;
    assign o_err_timeout = r_err_timeout;

endmodule
